// File: rtl/counter_seq_ctrl.sv
// Start/stop/clear sequencer, prescaled tick and ripple-free enables for a DIGITS-wide mod-10 chain,
// plus a valid/ready lap snapshot. Define COUNTER_SEQ_WRAP_EN to wrap at all-9s instead of stopping in DONE.
module counter_seq_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  lap,
  input  logic [4*DIGITS-1:0]   digits_in,
  output logic [DIGITS-1:0]     on,
  output logic                  ctr_reset,
  output logic [1:0]            state,
  output logic                  overflow,
  output logic                  snap_valid,
  input  logic                  snap_ready,
  output logic [4*DIGITS-1:0]   snap_data,
  output logic                  lap_miss
);

  localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                ctr_reset_q, ctr_reset_d;
  logic                overflow_q, overflow_d;
  logic                snap_valid_q, snap_valid_d;
  logic [4*DIGITS-1:0] snap_data_q, snap_data_d;
  logic                lap_miss_q, lap_miss_d;

  logic [DIGITS-1:0]   carry_in;
  logic                all9;
  logic                tick;
  logic                term;
  logic                snap_cap;

  // carry_in[i]: every stage below i reads 9, so stage i rolls with the tick
  always_comb begin
    logic run;
    run      = 1'b1;
    carry_in = '0;
    for (int i = 0; i < DIGITS; i++) begin
      carry_in[i] = run;
      run         = run & (digits_in[4*i +: 4] == 4'd9);
    end
    all9 = run;
  end

  assign tick = (state_q == S_RUN) && (presc_q == PRESC_MAX) && !stop && !clear;
  assign term = tick & all9;

`ifdef COUNTER_SEQ_WRAP_EN
  assign on = tick ? carry_in : '0;
`else
  // Saturate: the terminal tick is swallowed so the chain holds at all 9s
  assign on = (tick && !all9) ? carry_in : '0;
`endif

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    case (state_q)
      S_IDLE: begin
        if (!clear && !stop && start) begin
          state_d = S_RUN;
          presc_d = '0;
        end
      end
      S_RUN: begin
        if (clear) begin
          state_d = S_IDLE;
          presc_d = '0;
        end else if (stop) begin
          state_d = S_PAUSE;
        end else begin
          presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
`ifndef COUNTER_SEQ_WRAP_EN
          if (term) state_d = S_DONE;
`endif
        end
      end
      S_PAUSE: begin
        if (clear) begin
          state_d = S_IDLE;
          presc_d = '0;
        end else if (!stop && start) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (clear) begin
          state_d = S_IDLE;
          presc_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctr_reset_d  = clear;
    overflow_d   = term;
    snap_cap     = lap & (~snap_valid_q | snap_ready);
    snap_valid_d = snap_cap | (snap_valid_q & ~snap_ready);
    snap_data_d  = snap_cap ? digits_in : snap_data_q;
    lap_miss_d   = clear ? 1'b0 : (lap_miss_q | (lap & snap_valid_q & ~snap_ready));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      ctr_reset_q  <= 1'b1;
      overflow_q   <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_data_q  <= '0;
      lap_miss_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      ctr_reset_q  <= ctr_reset_d;
      overflow_q   <= overflow_d;
      snap_valid_q <= snap_valid_d;
      snap_data_q  <= snap_data_d;
      lap_miss_q   <= lap_miss_d;
    end
  end

  assign state      = state_q;
  assign ctr_reset  = ctr_reset_q;
  assign overflow   = overflow_q;
  assign snap_valid = snap_valid_q;
  assign snap_data  = snap_data_q;
  assign lap_miss   = lap_miss_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Randomized bench for counter_seq_ctrl: integer-count reference model, queued expectations, negedge monitor.
module tb_counter_seq_ctrl;

  localparam int DIGITS = 2;
  localparam int P      = 10;
  localparam int MAXC   = 100;
`ifdef COUNTER_SEQ_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0, snap_ready = 1'b0;
  logic [4*DIGITS-1:0] digits_in = '0;
  logic [DIGITS-1:0]   on;
  logic                ctr_reset, overflow, snap_valid, lap_miss;
  logic [1:0]          state;
  logic [4*DIGITS-1:0] snap_data;

  always #5 clk = ~clk;

  counter_seq_ctrl #(.DIGITS(DIGITS), .PRESCALE(P)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .digits_in(digits_in), .on(on), .ctr_reset(ctr_reset), .state(state),
    .overflow(overflow), .snap_valid(snap_valid), .snap_ready(snap_ready),
    .snap_data(snap_data), .lap_miss(lap_miss)
  );

  // External mod-10 stages driven by the DUT enables
  always @(posedge clk) begin
    for (int i = 0; i < DIGITS; i++) begin
      if (ctr_reset) digits_in[4*i +: 4] <= 4'd0;
      else if (on[i]) digits_in[4*i +: 4] <= (digits_in[4*i +: 4] == 4'd9) ? 4'd0 : digits_in[4*i +: 4] + 4'd1;
    end
  end

  typedef struct {
    logic [1:0] st;
    logic [1:0] on;
    logic       cr;
    logic       ov;
    logic       sv;
    logic       lm;
    int         cnt;
  } exp_t;

  exp_t                exp_q[$];
  logic [4*DIGITS-1:0] snap_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  int m_state = 0, m_presc = 0, m_count = 0;
  bit m_cr = 1'b1, m_ov = 1'b0, m_sv = 1'b0, m_lm = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  function automatic int bcd2int(input logic [4*DIGITS-1:0] b);
    int s = 0;
    for (int i = 0; i < DIGITS; i++) s += int'(b[4*i +: 4]) * (10 ** i);
    return s;
  endfunction

  function automatic logic [4*DIGITS-1:0] int2bcd(input int c);
    logic [4*DIGITS-1:0] b = '0;
    for (int i = 0; i < DIGITS; i++) b[4*i +: 4] = 4'((c / (10 ** i)) % 10);
    return b;
  endfunction

  // One clock cycle: drive inputs just after the edge, record expectations, advance the model
  task automatic cycle(input bit rst_n, input bit st, input bit sp, input bit cl, input bit lp, input bit rdy);
    exp_t e;
    bit   tick, term, acc;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0; snap_ready = rdy;
      m_state = 0; m_presc = 0; m_cr = 1'b1; m_ov = 1'b0; m_sv = 1'b0; m_lm = 1'b0;
      snap_q.delete();
      e = '{st: 2'd0, on: '0, cr: 1'b1, ov: 1'b0, sv: 1'b0, lm: 1'b0, cnt: m_count};
      exp_q.push_back(e);
      #1;
      chk("async_rst_state", state, 0);
      chk("async_rst_ctr_reset", ctr_reset, 1);
      chk("async_rst_on", on, 0);
      m_count = 0;
      return;
    end
    reset = 1'b1; start = st; stop = sp; clear = cl; lap = lp; snap_ready = rdy;
    tick = (m_state == 1) && (m_presc == P - 1) && !sp && !cl;
    term = tick && (m_count == MAXC - 1);
    e.st = 2'(m_state); e.cr = m_cr; e.ov = m_ov; e.sv = m_sv; e.lm = m_lm; e.cnt = m_count;
    e.on = '0;
    for (int i = 0; i < DIGITS; i++)
      e.on[i] = tick && !(term && !WRAP) && ((m_count % (10 ** i)) == (10 ** i) - 1);
    exp_q.push_back(e);
    acc = lp && (!m_sv || rdy);
    if (acc) snap_q.push_back(int2bcd(m_count));
    // next-cycle model
    if (m_cr) m_count = 0;
    else if (tick && !(term && !WRAP)) m_count = (m_count + 1) % MAXC;
    m_ov = term;
    m_cr = cl;
    m_lm = cl ? 1'b0 : (m_lm | (lp && m_sv && !rdy));
    m_sv = acc ? 1'b1 : (rdy ? 1'b0 : m_sv);
    case (m_state)
      0: if (!cl && !sp && st) begin m_state = 1; m_presc = 0; end
      1: if (cl) begin m_state = 0; m_presc = 0; end
         else if (!sp) begin
           m_presc = (m_presc + 1) % P;
           if (term && !WRAP) m_state = 3;
         end
         else m_state = 2;
      2: if (cl) begin m_state = 0; m_presc = 0; end
         else if (!sp && st) m_state = 1;
      default: if (cl) begin m_state = 0; m_presc = 0; end
    endcase
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1, 0, 0, 0, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 50);
  endtask

  task automatic rnd(input int n);
    for (int k = 0; k < n; k++)
      cycle(1, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 50);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state", state, e.st);
      chk("on", on, e.on);
      chk("ctr_reset", ctr_reset, e.cr);
      chk("overflow", overflow, e.ov);
      chk("snap_valid", snap_valid, e.sv);
      chk("lap_miss", lap_miss, e.lm);
      chk("count", bcd2int(digits_in), e.cnt);
      if (snap_valid) begin
        if (snap_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL snap_unexpected at %0t: snap_valid=1 with no capture outstanding", $time);
        end else begin
          chk("snap_data", snap_data, snap_q[0]);
          if (snap_ready) void'(snap_q.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
    idle(3);
    // run to terminal count and beyond
    cycle(1, 1, 0, 0, 0, 0);
    idle(1030);
    for (int k = 0; k < 3; k++) cycle(1, 1, 0, 0, 0, 1);
    cycle(1, 0, 0, 1, 0, 1);
    idle(3);
    // stop in the tick cycle, resume a few cycles later
    cycle(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 30; k++) begin
      if (m_state == 1 && m_presc == P - 1) break;
      idle(1);
    end
    cycle(1, 0, 1, 0, 0, 0);
    idle(4);
    cycle(1, 1, 0, 0, 0, 0);
    idle(25);
    // clear and start together while running
    cycle(1, 1, 1, 1, 0, 0);
    idle(5);
    // lap-capture contention: back-to-back laps with consumer stalled
    cycle(1, 1, 0, 0, 0, 0);
    idle(40);
    cycle(1, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1);
    idle(5);
    rnd(2000);
    // asynchronous reset mid-run at prescaler 6
    cycle(1, 0, 0, 1, 0, 1);
    cycle(1, 1, 0, 0, 0, 1);
    for (int k = 0; k < 30; k++) begin
      if (m_state == 1 && m_presc == 6) break;
      idle(1);
    end
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 0, 1);
    idle(30);
    for (int k = 0; k < 5; k++) cycle(1, 0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
